fifo_read_streamer: RTL and testbench

Read-side engine for a single-clock FIFO built on `dual_port_ram`. It owns the read pointer and computes RAM emptiness from the write pointer. It fetches words from the RAM's combinational read port and presents them on a first-word-fall-through valid/ready stream through a 2-entry output buffer, so the consumer sees full throughput. The read pointer is exported back to the write-side logic for the full calculation.

---
 rtl/fifo_read_streamer_pkg.sv | 18 +
 rtl/fifo_read_streamer_if.sv | 11 +
 rtl/fifo_read_streamer_skid.sv | 86 ++++++++
 rtl/fifo_read_streamer.sv | 62 ++++++
 tb/tb_fifo_read_streamer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_read_streamer_pkg.sv
// Shared definitions for the FIFO read side: occupancy encoding, default sizes
// and the pointer-width rule (one extra wrap bit above the RAM address).
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_read_streamer_if.sv
// First-word-fall-through valid/ready stream leaving the FIFO read side.
interface fifo_read_streamer_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_read_streamer_skid.sv
// Two-entry output buffer: head is always the presented word, tail catches a
// fetch that lands while the head is stalled.
module fifo_skid_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output occ_t                  o_occ
);
    occ_t                  r_occ;
    occ_t                  w_occ_next;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  w_load_head;
    logic                  w_load_tail;
    logic                  w_shift;

    always_comb begin
        w_occ_next  = r_occ;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        case (r_occ)
            EMPTY: begin
                if (i_push) begin
                    w_occ_next  = ONE;
                    w_load_head = 1'b1;
                end
            end
            ONE: begin
                // Pop and push together replace the head in place.
                if (i_push) begin
                    if (i_pop) begin
                        w_load_head = 1'b1;
                    end else begin
                        w_occ_next  = TWO;
                        w_load_tail = 1'b1;
                    end
                end else if (i_pop) begin
                    w_occ_next = EMPTY;
                end
            end
            TWO: begin
                if (i_pop) begin
                    w_shift = 1'b1;
                    if (i_push) begin
                        w_load_tail = 1'b1;
                    end else begin
                        w_occ_next = ONE;
                    end
                end
            end
            default: w_occ_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ  <= EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_occ <= w_occ_next;
            if (w_load_head) begin
                r_head <= i_data;
            end else if (w_shift) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_occ != EMPTY);
    assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_read_streamer.sv
// FIFO read engine: owns the read pointer, fetches from the RAM's combinational
// read port whenever the output buffer has room, and reports the RAM level.
module fifo_read_streamer
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int PTR_W      = ptr_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_W-1:0]      wptr,
    output logic [PTR_W-1:0]      rptr,
    output logic                  ram_read,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    fifo_read_streamer_if.master  m,
    output logic [PTR_W-1:0]      ram_level
);
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_level;
    logic [PTR_W-1:0] w_rptr_next;
    logic             w_ram_empty;
    logic             w_pop;
    logic             w_fetch;
    occ_t             w_occ;

    assign w_ram_empty = (r_rptr == wptr);
    assign w_pop       = m.m_valid & m.m_ready;
    // A full buffer can still take a word on the same edge it gives one away.
    assign w_fetch     = ~rst & ~w_ram_empty & ((w_occ != TWO) | w_pop);
    assign w_rptr_next = r_rptr + {{(PTR_W-1){1'b0}}, w_fetch};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_rptr  <= w_rptr_next;
            r_level <= wptr - w_rptr_next;
        end
    end

    fifo_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fetch),
        .i_data  (rdata),
        .i_pop   (w_pop),
        .o_data  (m.m_data),
        .o_valid (m.m_valid),
        .o_occ   (w_occ)
    );

    assign rptr      = r_rptr;
    assign raddr     = r_rptr[ADDR_WIDTH-1:0];
    assign ram_read  = w_fetch;
    assign ram_level = r_level;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboarded bench for fifo_read_streamer: written words are queued as
// expectations and a negedge monitor compares every word the stream hands over.
module tb_fifo_read_streamer;

    logic       clk;
    logic       rst;
    logic [3:0] wptr;
    logic [3:0] rptr;
    logic       ram_read;
    logic [2:0] raddr;
    logic [7:0] rdata;
    logic [3:0] ram_level;
    logic [7:0] mem [8];

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    logic [2:0] exp_raddr [4];
    logic [3:0] exp_rptr  [4];

    fifo_read_streamer_if #(.DATA_WIDTH(8)) s_if ();

    fifo_read_streamer #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wptr      (wptr),
        .rptr      (rptr),
        .ram_read  (ram_read),
        .raddr     (raddr),
        .rdata     (rdata),
        .m         (s_if),
        .ram_level (ram_level)
    );

    // Poison value stands in for the RAM's undriven bus when not reading.
    assign rdata = ram_read ? mem[raddr] : 8'hEE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && s_if.m_valid && s_if.m_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %0h expected none at %0t", s_if.m_data, $time);
            end else begin
                check("stream_data", 32'(s_if.m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wptr[2:0]] = d;
        wptr = wptr + 4'd1;
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wptr = 4'd0;
        s_if.m_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d words left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_raddr[0] = 3'd6; exp_raddr[1] = 3'd7; exp_raddr[2] = 3'd0; exp_raddr[3] = 3'd1;
        exp_rptr[0]  = 4'd15; exp_rptr[1] = 4'd0; exp_rptr[2]  = 4'd1; exp_rptr[3]  = 4'd2;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // Reset held two cycles with words already pending
        rst = 1'b1;
        s_if.m_ready = 1'b0;
        wptr = 4'd0;
        write_word(8'h31);
        write_word(8'h32);
        write_word(8'h33);
        tick();
        @(negedge clk);
        check("rst_m_valid", 32'(s_if.m_valid), 32'd0);
        check("rst_ram_read", 32'(ram_read), 32'd0);
        check("rst_rptr", 32'(rptr), 32'd0);
        check("rst_m_data", 32'(s_if.m_data), 32'd0);
        tick();
        rst = 1'b0;
        s_if.m_ready = 1'b1;
        wait_drain("reset");
        check("rst_rptr_after", 32'(rptr), 32'd3);

        // Single word
        do_reset();
        s_if.m_ready = 1'b1;
        write_word(8'hA5);
        @(negedge clk);
        check("single_ram_read", 32'(ram_read), 32'd1);
        check("single_raddr", 32'(raddr), 32'd0);
        @(negedge clk);
        check("single_m_valid", 32'(s_if.m_valid), 32'd1);
        check("single_m_data", 32'(s_if.m_data), 32'hA5);
        check("single_rptr", 32'(rptr), 32'd1);
        @(negedge clk);
        check("single_m_valid_off", 32'(s_if.m_valid), 32'd0);
        wait_drain("single");

        // Backpressure
        do_reset();
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        write_word(8'h44);
        repeat (3) tick();
        @(negedge clk);
        check("bp_rptr", 32'(rptr), 32'd2);
        check("bp_ram_read", 32'(ram_read), 32'd0);
        check("bp_m_data", 32'(s_if.m_data), 32'h11);
        check("bp_level", 32'(ram_level), 32'd2);
        tick();
        s_if.m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_no_bubble", 32'(s_if.m_valid), 32'd1);
        end
        wait_drain("bp");
        check("bp_level_zero", 32'(ram_level), 32'd0);
        check("bp_idle", 32'(s_if.m_valid), 32'd0);

        // Pointer wrap
        do_reset();
        s_if.m_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            write_word(8'h40 + 8'(i));
            tick();
        end
        wait_drain("wrap_prefill");
        @(negedge clk);
        check("wrap_rptr_start", 32'(rptr), 32'd14);
        tick();
        write_word(8'hC0);
        write_word(8'hC1);
        write_word(8'hC2);
        write_word(8'hC3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wrap_ram_read", 32'(ram_read), 32'd1);
            check("wrap_raddr", 32'(raddr), 32'(exp_raddr[k]));
            if (k > 0) check("wrap_rptr", 32'(rptr), 32'(exp_rptr[k-1]));
        end
        @(negedge clk);
        check("wrap_rptr", 32'(rptr), 32'(exp_rptr[3]));
        wait_drain("wrap");

        // Fetch and pop together while TWO
        do_reset();
        for (int i = 0; i < 6; i++) write_word(8'h61 + 8'(i));
        repeat (3) tick();
        @(negedge clk);
        check("two_occ_full", 32'(dut.w_occ), 32'd2);
        tick();
        s_if.m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("two_occ_steady", 32'(dut.w_occ), 32'd2);
            check("two_ram_read", 32'(ram_read), 32'd1);
        end
        wait_drain("two");

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) write_word(8'h71 + 8'(i));
        repeat (3) tick();
        @(negedge clk);
        check("mid_occ_two", 32'(dut.w_occ), 32'd2);
        check("mid_level", 32'(ram_level), 32'd3);
        tick();
        rst = 1'b1;
        wptr = 4'd0;
        exp_q.delete();
        @(negedge clk);
        check("mid_ram_read_rst", 32'(ram_read), 32'd0);
        tick();
        rst = 1'b0;
        s_if.m_ready = 1'b1;
        @(negedge clk);
        check("mid_m_valid", 32'(s_if.m_valid), 32'd0);
        check("mid_rptr", 32'(rptr), 32'd0);
        check("mid_m_data", 32'(s_if.m_data), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("mid_no_stale", 32'(s_if.m_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
